// File: rtl/ixc_bus26_arb_if.sv
// Bundle of requester-side and shared-path signals for the packet-locked arbiter.
// master is the traffic side (requesters plus downstream sink), slave is the arbiter.
interface ixc_bus26_arb_if #(
    parameter int W = 26,
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [IW-1:0]  grant_id;
    logic           busy;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, grant_id, busy
    );
endinterface

// File: rtl/ixc_bus26_arb.sv
// N-way round-robin arbiter that locks onto one requester for a whole packet
// and forwards its beats through a single registered W-bit output stage.
module ixc_bus26_arb #(
    parameter int W = 26,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    ixc_bus26_arb_if.slave bus
);
    // state | meaning
    // IDLE  | arbitration cycle: no req_ready, search req_valid from rr_ptr
    // XFER  | locked to grant_id until its last beat is accepted
    localparam int IW = $clog2(N);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_q;
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    logic [N-1:0]  ready;
    logic          take;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic          out_valid_q;
    logic          out_last_q;
    logic [W-1:0]  out_data_q;

    // N is a power of two, so the wrap N-1 -> 0 is plain truncation of rr_ptr + k.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = rr_ptr + IW'(k);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == XFER) begin
            ready[grant_q] = bus.out_ready | ~out_valid_q;
        end
    end

    assign take = (state == XFER) & bus.req_valid[grant_q] & ready[grant_q];

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == IW'(i)) begin
                sel_data = bus.req_data[i*W +: W];
                sel_last = bus.req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                grant_q <= pick;
                state   <= XFER;
            end
        end else begin
            if (take && sel_last) begin
                state  <= IDLE;
                rr_ptr <= grant_q + 1'b1;
            end
        end
    end

    // Output stage drains on out_ready regardless of FSM state; a load wins over a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state == XFER);
endmodule

// File: tb/tb_ixc_bus26_arb.sv
// Directed scenarios followed by randomized traffic, all checked cycle by cycle
// against a transaction-level reference of the arbitration and output-stage rules.
module tb_ixc_bus26_arb;
    localparam int W = 26;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ixc_bus26_arb_if #(.W(W), .N(N)) bus ();
    ixc_bus26_arb #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int failed = 0;
    int cyc_n = 0;

    logic [W:0] srcq [N][$];
    bit [N-1:0] gap;
    logic [W:0] obsq [$];
    int glog [$];
    int gcyc [$];
    bit pbusy;

    bit          m_xfer, m_ov, m_ol;
    int          m_gid, m_ptr;
    logic [W-1:0] m_od;
    bit [N-1:0]  m_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_xfer = 0; m_ov = 0; m_ol = 0; m_od = '0; m_gid = 0; m_ptr = 0; m_acc = '0;
    endtask

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_xfer && (bus.out_ready || !m_ov)) r[m_gid] = 1'b1;
        return r;
    endfunction

    task automatic push_pkt(input int i, input int len);
        for (int b = 0; b < len; b++) srcq[i].push_back({(b == len - 1), W'($urandom)});
    endtask

    task automatic drive();
        logic [W:0] b;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && !gap[i]) begin
                b = srcq[i][0];
                bus.req_valid[i] = 1'b1;
                bus.req_data[i*W +: W] = b[W-1:0];
                bus.req_last[i] = b[W];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[i*W +: W] = W'($urandom);
                bus.req_last[i] = 1'($urandom);
            end
        end
    endtask

    task automatic check();
        chk("req_ready", bus.req_ready, exp_ready());
        chk("out_valid", bus.out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", bus.out_data, m_od);
            chk("out_last", bus.out_last, m_ol);
        end
        chk("busy", bus.busy, m_xfer);
        if (m_xfer) chk("grant_id", bus.grant_id, m_gid);
        if (bus.busy && !pbusy) begin
            glog.push_back(int'(bus.grant_id));
            gcyc.push_back(cyc_n);
        end
        pbusy = bus.busy;
        if (bus.out_valid && bus.out_ready) obsq.push_back({bus.out_last, bus.out_data});
    endtask

    // Reference: one step of the arbitration and output-register rules at a clock edge.
    task automatic model_edge();
        logic [N-1:0] er;
        bit acc;
        int j;
        m_acc = '0;
        if (rst) begin
            model_reset();
            return;
        end
        er  = exp_ready();
        acc = m_xfer && bus.req_valid[m_gid] && er[m_gid];
        if (acc) begin
            m_acc[m_gid] = 1'b1;
            m_ov = 1;
            m_od = bus.req_data[m_gid*W +: W];
            m_ol = bus.req_last[m_gid];
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0;
        end
        if (!m_xfer) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (bus.req_valid[j]) begin
                    m_gid = j;
                    m_xfer = 1;
                    break;
                end
            end
        end else if (acc && bus.req_last[m_gid]) begin
            m_xfer = 0;
            m_ptr = (m_gid + 1) % N;
        end
    endtask

    task automatic tick();
        drive();
        #2;
        check();
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (m_acc[i]) void'(srcq[i].pop_front());
        cyc_n++;
    endtask

    initial begin
        logic [W-1:0] bp_exp [3];
        bp_exp[0] = 26'h0111111;
        bp_exp[1] = 26'h0222222;
        bp_exp[2] = 26'h0333333;

        rst = 1'b1;
        bus.out_ready = 1'b1;
        gap = '0;
        pbusy = 0;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rst = 1'b0;

        // All four requesters, two single-beat packets each
        for (int i = 0; i < N; i++) for (int p = 0; p < 2; p++) srcq[i].push_back({1'b1, W'($urandom)});
        glog.delete(); gcyc.delete();
        repeat (18) tick();
        chk("rr_count", glog.size(), 8);
        for (int k = 0; k < 5; k++) chk("rr_order", glog[k], k % N);
        for (int k = 1; k < 5; k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 2);

        // Single requester 2
        srcq[2].push_back({1'b1, 26'h2AAAAAA});
        tick();
        chk("single_grant", bus.grant_id, 2);
        chk("single_busy1", bus.busy, 1);
        tick();
        chk("single_valid", bus.out_valid, 1);
        chk("single_data", bus.out_data, 26'h2AAAAAA);
        chk("single_last", bus.out_last, 1);
        tick();
        chk("single_busy3", bus.busy, 0);
        chk("single_drained", bus.out_valid, 0);

        // Wrap from rr_ptr=3
        glog.delete();
        push_pkt(0, 1);
        push_pkt(3, 1);
        repeat (6) tick();
        chk("wrap_count", glog.size(), 2);
        chk("wrap_first", glog[0], 3);
        chk("wrap_second", glog[1], 0);

        // Mid-packet gap on requester 0 while requester 3 waits
        glog.delete();
        push_pkt(0, 3);
        tick(); tick();
        gap[0] = 1'b1;
        push_pkt(3, 1);
        repeat (3) begin
            tick();
            chk("gap_busy", bus.busy, 1);
            chk("gap_lock", bus.grant_id, 0);
        end
        gap[0] = 1'b0;
        repeat (8) tick();
        chk("gap_count", glog.size(), 2);
        chk("gap_first", glog[0], 0);
        chk("gap_next", glog[1], 3);

        // Backpressure on a 3-beat packet from requester 1
        obsq.delete();
        for (int b = 0; b < 3; b++) srcq[1].push_back({(b == 2), bp_exp[b]});
        tick(); tick();
        chk("bp_first_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        repeat (5) begin
            drive();
            #1;
            chk("bp_ready", bus.req_ready[1], 0);
            tick();
            chk("bp_hold", bus.out_data, bp_exp[0]);
        end
        bus.out_ready = 1'b1;
        repeat (8) tick();
        chk("bp_beats", obsq.size(), 3);
        for (int b = 0; b < 3; b++) chk("bp_beat", obsq[b], {(b == 2), bp_exp[b]});

        // Reset during XFER with a pending output beat
        push_pkt(2, 3);
        tick(); tick();
        chk("rx_pre_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_out_valid", bus.out_valid, 0);
        chk("rx_busy", bus.busy, 0);
        chk("rx_out_last", bus.out_last, 0);
        chk("rx_out_data", bus.out_data, 0);
        srcq[2].delete();
        bus.out_ready = 1'b1;
        glog.delete(); obsq.delete();
        push_pkt(1, 1);
        push_pkt(3, 1);
        repeat (6) tick();
        chk("rx_count", glog.size(), 2);
        chk("rx_first", glog[0], 1);
        chk("rx_second", glog[1], 3);
        chk("rx_beats", obsq.size(), 2);

        // Randomized traffic with gaps, backpressure and occasional reset
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) push_pkt(i, $urandom_range(1, 4));
            for (int i = 0; i < N; i++) gap[i] = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
            obsq.delete();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ixc_bus26_arb.md
IXC_BUS26_ARB -- requirements
Module: ixc_bus26_arb

Interface
REQ-001 SHALL have parameter W, default 26, meaning width of the shared data path in bits.
REQ-002 SHALL have parameter N, default 4, meaning number of requesters (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  N  per-requester beat valid.
REQ-006 SHALL have port req_data  input  N*W  per-requester data; requester i occupies bits [i*W +: W].
REQ-007 SHALL have port req_last  input  N  per-requester last-beat-of-packet flag.
REQ-008 SHALL have port req_ready  output  N  per-requester beat accept.
REQ-009 SHALL have port out_valid  output  1  shared path beat valid.
REQ-010 SHALL have port out_data  output  W  shared path data.
REQ-011 SHALL have port out_last  output  1  shared path last flag.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port grant_id  output  log2(N)  index of the locked requester; valid while busy=1.
REQ-014 SHALL have port busy  output  1  high in XFER state.

Function
REQ-015 SHALL implement two states: IDLE and XFER.
REQ-016 In IDLE, SHALL assert no req_ready and SHALL search req_valid round-robin starting at index rr_ptr, wrapping N-1 -> 0.
REQ-017 In IDLE with at least one req_valid set, SHALL latch the first found index into grant_id and enter XFER next cycle; otherwise remain in IDLE.
REQ-018 In XFER, SHALL drive req_ready[grant_id] = out_ready | ~out_valid and all other req_ready bits 0.
REQ-019 An input beat SHALL transfer when req_valid[grant_id] & req_ready[grant_id]; req_data and req_last of grant_id SHALL load into the output register the same edge, setting out_valid=1.
REQ-020 Output register SHALL hold out_valid, out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-021 When out_valid & out_ready and no new beat loads, out_valid SHALL clear next cycle; load and drain in the same cycle SHALL replace the register contents with out_valid remaining 1.
REQ-022 Latency: beat accepted at edge k SHALL appear on out_data after edge k; first beat of a packet SHALL reach out_valid no earlier than 2 cycles after req_valid rises in IDLE.
REQ-023 out_data SHALL equal the accepted req_data bit-for-bit; no width change, no transformation.
REQ-024 Accepting a beat with req_last=1 SHALL return the FSM to IDLE next cycle and set rr_ptr = (grant_id+1) mod N.
REQ-025 Lock SHALL persist while the granted requester deasserts req_valid mid-packet; other requesters SHALL NOT be granted until its last beat is accepted.
REQ-026 Output register drain SHALL be independent of FSM state; a pending beat in IDLE SHALL still complete on out_ready.
REQ-027 Between packets SHALL insert exactly one arbitration cycle (IDLE) with no req_ready asserted.

Reset
REQ-028 On rst=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, grant_id=0, busy=0, out_valid=0, out_last=0, out_data=0, req_ready=0.
REQ-029 Reset mid-packet or with a pending output beat SHALL discard that beat; no partial packet SHALL resume after reset.

Verification
REQ-030 Single requester: req_valid[2]=1, req_last[2]=1, req_data=0x2AAAAAA, out_ready=1 -> grant_id=2 cycle 1, out_valid=1 with out_data=0x2AAAAAA, out_last=1 cycle 2, busy=0 cycle 3, rr_ptr=3.
REQ-031 All four request single-beat packets continuously, out_ready=1 -> grant order 0,1,2,3,0 with one idle cycle between packets.
REQ-032 Backpressure: 3-beat packet from requester 1, out_ready=0 for 5 cycles after first beat -> out_data holds beat 0, req_ready[1]=0, no beat lost or duplicated after out_ready=1.
REQ-033 Mid-packet gap: requester 0 sends beat 0, drops req_valid 3 cycles while requester 3 requests -> grant_id stays 0 until its last beat, then requester 1..3 search grants 3.
REQ-034 Reset during XFER with out_valid=1 -> next cycle out_valid=0, busy=0, rr_ptr=0; subsequent request from requester 1 granted normally.
REQ-035 Wrap: rr_ptr=3, requests from 0 and 3 -> 3 granted first, then 0.
